// File: rtl/vip_packet_scheduler_if.sv
// vip_packet_scheduler_if: Avalon-ST pixel sink and VIP source bundle for the frame scheduler.
interface vip_packet_scheduler_if #(parameter int DW = 24);
   logic [DW-1:0] snk_data;
   logic snk_valid, snk_ready;
   logic [DW-1:0] src_data;
   logic src_valid, src_ready, src_sop, src_eop;
   modport master (input snk_data, snk_valid, src_ready, output snk_ready, src_data, src_valid, src_sop, src_eop);
   modport slave (output snk_data, snk_valid, src_ready, input snk_ready, src_data, src_valid, src_sop, src_eop);
endinterface

// File: rtl/vip_packet_scheduler.sv
// vip_packet_scheduler: per-frame control packet, video header, then width*height pixels.
// VIP_SCHED_CTRL_REPEAT_EN: send a control packet before every frame, not only after a config change.
module vip_packet_scheduler #(parameter int DW = 24) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic [15:0] cfg_width,
   input  logic [15:0] cfg_height,
   input  logic [3:0] cfg_interlace,
   input  logic cfg_valid,
   output logic cfg_err,
   output logic busy,
   output logic frame_done,
   vip_packet_scheduler_if.master bus
);
   typedef enum logic [1:0] {IDLE, CTRL, VHDR, PIX} state_t;
   state_t state, state_nx;
   logic [15:0] sh_w, sh_h, act_w, act_h, x, y;
   logic [3:0] sh_il, act_il;
   logic [1:0] beat;
   logic [DW-1:0] ctrl_data;
   logic sh_ok, pending, cfg_bad, cfg_load, accept, last, start, go, with_ctrl;
   assign cfg_bad = cfg_width == '0 || cfg_height == '0;
   assign cfg_load = cfg_valid && !cfg_bad;
   assign accept = bus.src_valid && bus.src_ready;
   assign last = x == act_w - 16'd1 && y == act_h - 16'd1;
   assign start = enable && sh_ok;
   assign go = start && (state == IDLE || frame_done);
   assign busy = state != IDLE;
`ifdef VIP_SCHED_CTRL_REPEAT_EN
   assign with_ctrl = 1'b1;
`else
   assign with_ctrl = pending;
`endif
   always_comb begin
      ctrl_data = beat == 2'd0 ? 24'h00000F :
                  beat == 2'd1 ? {4'h0, act_w[7:4], 4'h0, act_w[11:8], 4'h0, act_w[15:12]} :
                  beat == 2'd2 ? {4'h0, act_h[11:8], 4'h0, act_h[15:12], 4'h0, act_w[3:0]} :
                                 {4'h0, act_il, 4'h0, act_h[3:0], 4'h0, act_h[7:4]};
      bus.src_valid = state == CTRL || state == VHDR || (state == PIX && bus.snk_valid);
      bus.src_data = state == PIX ? bus.snk_data : state == CTRL ? ctrl_data : '0;
      bus.src_sop = (state == CTRL && beat == 2'd0) || state == VHDR;
      bus.src_eop = (state == CTRL && beat == 2'd3) || (state == PIX && last);
      bus.snk_ready = state == PIX && bus.src_ready;
      frame_done = state == PIX && accept && last;
      state_nx = state;
      case (state)
         IDLE: state_nx = start ? (with_ctrl ? CTRL : VHDR) : IDLE;
         CTRL: state_nx = accept && beat == 2'd3 ? VHDR : CTRL;
         VHDR: state_nx = accept ? PIX : VHDR;
         PIX:  state_nx = !frame_done ? PIX : start ? (with_ctrl ? CTRL : VHDR) : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cfg_err <= 1'b0;
         sh_ok <= 1'b0;
         pending <= 1'b0;
         {sh_w, sh_h, sh_il} <= '0;
         {act_w, act_h, act_il} <= '0;
         beat <= '0;
         x <= '0;
         y <= '0;
      end else begin
         state <= state_nx;
         cfg_err <= cfg_valid && cfg_bad;
         if (cfg_load) begin
            {sh_w, sh_h, sh_il} <= {cfg_width, cfg_height, cfg_interlace};
            sh_ok <= 1'b1;
         end
         // a write landing on a frame-start edge stays pending for the following frame
         pending <= cfg_load || (pending && !go);
         if (go) {act_w, act_h, act_il} <= {sh_w, sh_h, sh_il};
         beat <= state == CTRL && accept ? beat + 2'd1 : beat;
         if (state == PIX && accept) begin
            x <= x == act_w - 16'd1 ? '0 : x + 16'd1;
            y <= x != act_w - 16'd1 ? y : last ? '0 : y + 16'd1;
         end
      end
   end
endmodule
